// File: rtl/mux_rr_pkg.sv
// Shared types and constants for the round-robin output mux (mux_rr_arb).
// The lock state type is only used when MUX_RR_LOCK_EN is defined.
package mux_rr_pkg;

   localparam int RST_PTR = 0;
   localparam int MAX_NCH = 16;

   typedef enum logic [0:0] {
      ARB  = 1'b0,
      LOCK = 1'b1
   } lock_st_t;

   // Ceiling log2, minimum result 1 so a 2-channel build still gets a 1-bit id.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 32; i++) begin
         result = ((32'd1 << i) < value) ? (i + 1) : result;
      end
      return result;
   endfunction

endpackage

// File: rtl/mux_rr_arb_if.sv
// Request/output bundle of mux_rr_arb. req_last exists only when
// MUX_RR_LOCK_EN is defined (packet lock build).
interface mux_rr_arb_if #(
   parameter int DWIDTH = 2,
   parameter int NCH    = 4
);
   localparam int CHW = mux_rr_pkg::clog2(NCH);

   logic [NCH-1:0]        req_vld;
   logic [NCH*DWIDTH-1:0] req_data;
   logic [NCH-1:0]        req_rdy;
`ifdef MUX_RR_LOCK_EN
   logic [NCH-1:0]        req_last;
`endif
   logic                  dout_vld;
   logic [DWIDTH-1:0]     dout;
   logic [CHW-1:0]        dout_ch;
   logic                  dout_rdy;

`ifdef MUX_RR_LOCK_EN
   modport master (
      output req_vld, req_data, req_last, dout_rdy,
      input  req_rdy, dout_vld, dout, dout_ch
   );

   modport slave (
      input  req_vld, req_data, req_last, dout_rdy,
      output req_rdy, dout_vld, dout, dout_ch
   );
`else
   modport master (
      output req_vld, req_data, dout_rdy,
      input  req_rdy, dout_vld, dout, dout_ch
   );

   modport slave (
      input  req_vld, req_data, dout_rdy,
      output req_rdy, dout_vld, dout, dout_ch
   );
`endif

endinterface

// File: rtl/rr_arb_core.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping, found by rotating a doubled request vector and priority-encoding.
module rr_arb_core #(
   parameter int NCH = 4,
   parameter int CHW = 2
) (
   input  logic [NCH-1:0] req,
   input  logic [CHW-1:0] ptr,
   output logic [NCH-1:0] gnt,
   output logic [CHW-1:0] gnt_id,
   output logic           any
);

   logic [NCH-1:0] rot_s;
   logic [CHW-1:0] off_s;
   logic [CHW:0]   sum_s;

   assign rot_s = NCH'({req, req} >> ptr);
   assign any   = |req;

   // Lowest set bit of the rotated vector is the distance from ptr to the winner.
   always_comb begin
      off_s = {CHW{1'b0}};
      for (int i = NCH - 1; i >= 0; i--) begin
         off_s = rot_s[i] ? CHW'(i) : off_s;
      end
   end

   // Undo the rotation modulo NCH, which need not be a power of two.
   always_comb begin
      sum_s = {1'b0, ptr} + {1'b0, off_s};
      if (sum_s >= (CHW+1)'(NCH)) begin
         gnt_id = CHW'(sum_s - (CHW+1)'(NCH));
      end else begin
         gnt_id = sum_s[CHW-1:0];
      end
   end

   assign gnt = any ? (NCH'(1) << gnt_id) : {NCH{1'b0}};

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel registered round-robin mux with valid/ready on both sides.
// Define MUX_RR_LOCK_EN to hold the grant on one channel until req_last.
module mux_rr_arb
   import mux_rr_pkg::*;
#(
   parameter int DWIDTH = 2,
   parameter int NCH    = 4
) (
   input logic         clk,
   input logic         rst_l,
   mux_rr_arb_if.slave bus
);

   localparam int CHW = clog2(NCH);

   logic [CHW-1:0]    ptr_r;
   logic              dout_vld_r;
   logic [DWIDTH-1:0] dout_r;
   logic [CHW-1:0]    dout_ch_r;

   logic [NCH-1:0]    arb_req_s;
   logic [NCH-1:0]    gnt_s;
   logic [CHW-1:0]    gnt_id_s;
   logic [CHW-1:0]    ptr_nxt_s;
   logic              any_s;
   logic              load_ok_s;
   logic              accept_s;
   logic              last_s;
   logic [DWIDTH-1:0] sel_data_s;

   rr_arb_core #(
      .NCH (NCH),
      .CHW (CHW)
   ) u_core (
      .req    (arb_req_s),
      .ptr    (ptr_r),
      .gnt    (gnt_s),
      .gnt_id (gnt_id_s),
      .any    (any_s)
   );

   assign load_ok_s = !dout_vld_r || bus.dout_rdy;
   assign accept_s  = any_s && load_ok_s;
   assign ptr_nxt_s = (gnt_id_s == CHW'(NCH - 1)) ? {CHW{1'b0}} : (gnt_id_s + CHW'(1));

`ifdef MUX_RR_LOCK_EN
   lock_st_t       state_r;
   lock_st_t       state_nxt_s;
   logic [CHW-1:0] lch_r;
   logic [NCH-1:0] lch_mask_s;

   assign lch_mask_s = NCH'(1) << lch_r;
   assign arb_req_s  = (state_r == LOCK) ? (bus.req_vld & lch_mask_s) : bus.req_vld;
   assign last_s     = bus.req_last[gnt_id_s];

   // Lock FSM next state: a non-final beat locks, the final beat of lch releases.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ARB: begin
            if (accept_s && !last_s) begin
               state_nxt_s = LOCK;
            end else begin
               state_nxt_s = ARB;
            end
         end
         LOCK: begin
            if (accept_s && last_s) begin
               state_nxt_s = ARB;
            end else begin
               state_nxt_s = LOCK;
            end
         end
         default: state_nxt_s = ARB;
      endcase
   end

   // Lock FSM state and the captured locked channel.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_r <= ARB;
         lch_r   <= CHW'(RST_PTR);
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ARB) && (state_nxt_s == LOCK)) begin
            lch_r <= gnt_id_s;
         end else begin
            lch_r <= lch_r;
         end
      end
   end
`else
   assign arb_req_s = bus.req_vld;
   assign last_s    = 1'b1;
`endif

   // AND-OR select of the granted channel's data; gnt_s is one-hot or zero.
   always_comb begin
      sel_data_s = {DWIDTH{1'b0}};
      for (int k = 0; k < NCH; k++) begin
         sel_data_s = sel_data_s | ({DWIDTH{gnt_s[k]}} & bus.req_data[k*DWIDTH +: DWIDTH]);
      end
   end

   // Output register: load on accept, drop valid when draining with nothing to load.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         dout_vld_r <= 1'b0;
         dout_r     <= {DWIDTH{1'b0}};
         dout_ch_r  <= {CHW{1'b0}};
      end else if (load_ok_s) begin
         dout_vld_r <= accept_s;
         if (accept_s) begin
            dout_r    <= sel_data_s;
            dout_ch_r <= gnt_id_s;
         end else begin
            dout_r    <= dout_r;
            dout_ch_r <= dout_ch_r;
         end
      end else begin
         dout_vld_r <= dout_vld_r;
      end
   end

   // Round-robin pointer moves past the winner only at packet end.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         ptr_r <= CHW'(RST_PTR);
      end else if (accept_s && last_s) begin
         ptr_r <= ptr_nxt_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign bus.req_rdy  = load_ok_s ? gnt_s : {NCH{1'b0}};
   assign bus.dout_vld = dout_vld_r;
   assign bus.dout     = dout_r;
   assign bus.dout_ch  = dout_ch_r;

endmodule
